// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EXE payload, extracts/merges load data, hands off to WB.
// Optional MS_RDATA_BUFFER_EN keeps SRAM read data stable across WB backpressure.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    input  logic [70:0] es_to_ms_bus,
    input  logic [6:0]  es_load_mem_bus,
    input  logic [31:0] es_rt_value,
    input  logic        flush,
    input  logic        ws_allowin,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic        ms_write_reg,
    output logic [4:0]  ms_reg_dest,
    output logic [31:0] ms_to_ds_bus,
    output logic        ms_read_mem_stall
);

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_ms_t;

    typedef struct packed {
        logic [1:0] width;
        logic       sign;
        logic [1:0] lr;
        logic [1:0] addr;
    } ld_t;

    logic        ms_valid;
    logic        ms_ready_go;
    es_ms_t      ms;
    ld_t         ld;
    logic [31:0] ms_rt;
    logic [31:0] rd;
    logic [31:0] final_result;
    logic [15:0] hsel;
    logic [7:0]  bsel;

    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset)
            ms_valid <= 1'b0;
        else if (flush)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= es_to_ms_valid;
    end

    // Payload is qualified by ms_valid everywhere it matters, so no reset here.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms    <= es_to_ms_bus;
            ld    <= es_load_mem_bus;
            ms_rt <= es_rt_value;
        end
    end

`ifdef MS_RDATA_BUFFER_EN
    logic        buf_valid;
    logic [31:0] rdata_buf;
    logic        capture;
    logic        leave;

    assign capture = ms_valid & ms.res_from_mem & ~buf_valid;
    assign leave   = ms_to_ws_valid & ws_allowin;

    always_ff @(posedge clk) begin
        if (reset || flush || leave)
            buf_valid <= 1'b0;
        else if (capture)
            buf_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (capture)
            rdata_buf <= data_sram_rdata;
    end

    // The live SRAM data is correct in the capture cycle, so loads never wait.
    assign ms_ready_go = ~ms.res_from_mem | buf_valid | capture;
    assign rd          = buf_valid ? rdata_buf : data_sram_rdata;
`else
    assign ms_ready_go = 1'b1;
    assign rd          = data_sram_rdata;
`endif

    always_comb begin
        hsel = ld.addr[1] ? rd[31:16] : rd[15:0];
        case (ld.addr)
            2'd0:    bsel = rd[7:0];
            2'd1:    bsel = rd[15:8];
            2'd2:    bsel = rd[23:16];
            default: bsel = rd[31:24];
        endcase
    end

    always_comb begin
        final_result = rd;
        if (!ms.res_from_mem) begin
            final_result = ms.alu_result;
        end else begin
            case (ld.width)
                2'b11: final_result = rd;
                2'b10: final_result = {{16{ld.sign & hsel[15]}}, hsel};
                2'b01: final_result = {{24{ld.sign & bsel[7]}}, bsel};
                default: begin
                    // Unaligned word merge; lr 00/11 falls through to raw rdata.
                    if (ld.lr == 2'b10) begin
                        case (ld.addr)
                            2'd0:    final_result = {rd[7:0],  ms_rt[23:0]};
                            2'd1:    final_result = {rd[15:0], ms_rt[15:0]};
                            2'd2:    final_result = {rd[23:0], ms_rt[7:0]};
                            default: final_result = rd;
                        endcase
                    end else if (ld.lr == 2'b01) begin
                        case (ld.addr)
                            2'd0:    final_result = rd;
                            2'd1:    final_result = {ms_rt[31:24], rd[31:8]};
                            2'd2:    final_result = {ms_rt[31:16], rd[31:16]};
                            default: final_result = {ms_rt[31:8],  rd[31:24]};
                        endcase
                    end
                end
            endcase
        end
    end

    assign ms_to_ws_bus      = {ms.gr_we, ms.dest, final_result, ms.pc};
    assign ms_write_reg      = ms.gr_we & ms_valid;
    assign ms_reg_dest       = ms.dest;
    assign ms_to_ds_bus      = final_result;
    assign ms_read_mem_stall = ms_valid & ms.res_from_mem & ~ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: handshake, load extraction, flush and reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [70:0] es_to_ms_bus;
    logic [6:0]  es_load_mem_bus;
    logic [31:0] es_rt_value;
    logic        flush;
    logic        ws_allowin;
    logic [31:0] data_sram_rdata;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ms_write_reg;
    logic [4:0]  ms_reg_dest;
    logic [31:0] ms_to_ds_bus;
    logic        ms_read_mem_stall;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .es_load_mem_bus(es_load_mem_bus), .es_rt_value(es_rt_value),
        .flush(flush), .ws_allowin(ws_allowin), .data_sram_rdata(data_sram_rdata),
        .ms_allowin(ms_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus), .ms_write_reg(ms_write_reg),
        .ms_reg_dest(ms_reg_dest), .ms_to_ds_bus(ms_to_ds_bus),
        .ms_read_mem_stall(ms_read_mem_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [70:0] mk_bus(input logic rfm, input logic we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {rfm, we, dest, alu, pc};
    endfunction

    function automatic logic [6:0] mk_ld(input logic [1:0] w, input logic s,
                                         input logic [1:0] lr, input logic [1:0] a);
        return {w, s, lr, a};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one load into MEM, then present SRAM data and check the merged result.
    task automatic load_case(input string tag, input logic [6:0] ld, input logic [31:0] rt,
                             input logic [31:0] rdata, input logic [31:0] exp);
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = mk_bus(1'b1, 1'b1, 5'd7, 32'h0000_1000, 32'hBFC0_0100);
        es_load_mem_bus = ld;
        es_rt_value     = rt;
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rdata;
        #1;
        chk(tag, {38'd0, ms_to_ds_bus}, {38'd0, exp});
        chk({tag, "_vld"}, {69'd0, ms_to_ws_valid}, 70'd1);
    endtask

    initial begin
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_load_mem_bus = '0;
        es_rt_value = '0; flush = 1'b0; ws_allowin = 1'b1; data_sram_rdata = '0;
        tick(); tick();
        chk("rst_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_allowin",  {69'd0, ms_allowin},     70'd1);
        chk("rst_write_reg", {69'd0, ms_write_reg},  70'd0);
        chk("rst_stall",    {69'd0, ms_read_mem_stall}, 70'd0);
        reset = 1'b0;

        // ADD followed directly by LW
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = mk_bus(1'b0, 1'b1, 5'd3, 32'h0000_00A5, 32'hBFC0_0000);
        es_load_mem_bus = '0;
        tick();
        es_to_ms_bus    = mk_bus(1'b1, 1'b1, 5'd4, 32'h0000_2000, 32'hBFC0_0004);
        es_load_mem_bus = mk_ld(2'b11, 1'b0, 2'b00, 2'b00);
        data_sram_rdata = 32'hDEAD_0000;
        #1;
        chk("add_ws_valid", {69'd0, ms_to_ws_valid}, 70'd1);
        chk("add_ds_bus",   {38'd0, ms_to_ds_bus}, {38'd0, 32'h0000_00A5});
        chk("add_ws_bus",   ms_to_ws_bus, {1'b1, 5'd3, 32'h0000_00A5, 32'hBFC0_0000});
        chk("add_write_reg", {69'd0, ms_write_reg}, 70'd1);
        chk("add_allowin",  {69'd0, ms_allowin}, 70'd1);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("lw_ds_bus",   {38'd0, ms_to_ds_bus}, {38'd0, 32'hCAFE_F00D});
        chk("lw_ws_valid", {69'd0, ms_to_ws_valid}, 70'd1);
        chk("lw_dest",     {65'd0, ms_reg_dest}, {65'd0, 5'd4});
        chk("lw_stall",    {69'd0, ms_read_mem_stall}, 70'd0);
        tick();
        chk("idle_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("idle_allowin",  {69'd0, ms_allowin}, 70'd1);

        // Sub-word and merge loads
        load_case("lb_sx_a3",   mk_ld(2'b01, 1'b1, 2'b00, 2'd3), 32'h0, 32'h80FF_0000, 32'hFFFF_FF80);
        load_case("lhu_a2",     mk_ld(2'b10, 1'b0, 2'b00, 2'd2), 32'h0, 32'hBEEF_1234, 32'h0000_BEEF);
        load_case("lh_sx_a0",   mk_ld(2'b10, 1'b1, 2'b00, 2'd0), 32'h0, 32'h0000_8001, 32'hFFFF_8001);
        load_case("lbu_a1",     mk_ld(2'b01, 1'b0, 2'b00, 2'd1), 32'h0, 32'h0000_AB00, 32'h0000_00AB);
        load_case("lwl_a1",     mk_ld(2'b00, 1'b0, 2'b10, 2'd1), 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        load_case("lwr_a1",     mk_ld(2'b00, 1'b0, 2'b01, 2'd1), 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
        load_case("lwl_a0",     mk_ld(2'b00, 1'b0, 2'b10, 2'd0), 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344);
        load_case("lwr_a3",     mk_ld(2'b00, 1'b0, 2'b01, 2'd3), 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA);
        load_case("undef_lr00", mk_ld(2'b00, 1'b0, 2'b00, 2'd2), 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
        tick();

        // Stalled load: payload holds, then flush drops it
        ws_allowin = 1'b0;
        load_case("stall_lw", mk_ld(2'b11, 1'b0, 2'b00, 2'd0), 32'h0, 32'h0BAD_0001, 32'h0BAD_0001);
        chk("stall_allowin", {69'd0, ms_allowin}, 70'd0);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b0, 1'b1, 5'd9, 32'h0, 32'h0);
        tick();
        es_to_ms_valid = 1'b0;
        chk("stall_hold_dest", {65'd0, ms_reg_dest}, {65'd0, 5'd7});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_ws_valid",  {69'd0, ms_to_ws_valid}, 70'd0);
        chk("flush_allowin",   {69'd0, ms_allowin}, 70'd1);
        chk("flush_write_reg", {69'd0, ms_write_reg}, 70'd0);
        ws_allowin = 1'b1;
        load_case("post_flush_lw", mk_ld(2'b11, 1'b0, 2'b00, 2'd0), 32'h0, 32'h5555_AAAA, 32'h5555_AAAA);
        tick();

`ifdef MS_RDATA_BUFFER_EN
        // Buffered read data survives WB backpressure while SRAM output changes
        ws_allowin = 1'b0;
        load_case("buf_lw", mk_ld(2'b11, 1'b0, 2'b00, 2'd0), 32'h0, 32'h1234_5678, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_rdata = 32'h0;
            #1;
            chk("buf_hold", {38'd0, ms_to_ds_bus}, {38'd0, 32'h1234_5678});
            chk("buf_hold_vld", {69'd0, ms_to_ws_valid}, 70'd1);
        end
        ws_allowin = 1'b1;
        #1;
        chk("buf_handoff", {38'd0, ms_to_ds_bus}, {38'd0, 32'h1234_5678});
        chk("buf_handoff_allowin", {69'd0, ms_allowin}, 70'd1);
        tick();
        chk("buf_left", {69'd0, ms_to_ws_valid}, 70'd0);
`endif

        // Reset in the middle of a stall discards the payload
        ws_allowin = 1'b0;
        load_case("rst_stall_lw", mk_ld(2'b11, 1'b0, 2'b00, 2'd0), 32'h0, 32'hFEED_BEEF, 32'hFEED_BEEF);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("midrst_allowin",  {69'd0, ms_allowin}, 70'd1);
        chk("midrst_stall",    {69'd0, ms_read_mem_stall}, 70'd0);
        ws_allowin = 1'b1;
        load_case("post_rst_lw", mk_ld(2'b11, 1'b0, 2'b00, 2'd0), 32'h0, 32'h0000_0077, 32'h0000_0077);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
